// File: rtl/sm_np.sv
// sm_np: parametrised N-state event-counting FSM with per-state output decode,
// wrap pulse and saturating wrap counter.
module sm_np #(
  parameter int N = 4,
  parameter logic [N-1:0] Y_MASK = N'(4'b1010),
  parameter bit EDGE_MODE = 1'b0,
  parameter int IDLE_FROM_LAST = 1,
  parameter int CW = 8,
  localparam int W = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  input  logic          dir,
  input  logic          x,
  output logic [W-1:0]  state,
  output logic          y,
  output logic          wrap,
  output logic [CW-1:0] wrap_cnt
);
  localparam int SW = 1 << W;
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] IDLE = W'(IDLE_FROM_LAST);
  logic [SW-1:0] mask_ext;
  logic          x_q, evt, at_last, at_zero, bad;
  logic [W-1:0]  state_q, state_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign mask_ext = SW'(Y_MASK);
  always_comb begin
    evt     = EDGE_MODE ? (x & ~x_q) : x;
    at_last = state_q == LAST;
    at_zero = state_q == '0;
    bad     = (N < SW) && (state_q > LAST);
    wrap_d  = !bad && evt && (dir ? at_zero : at_last);
    state_d = bad ? '0 :
              dir ? (evt ? (at_zero ? LAST : state_q - W'(1)) : state_q)
                  : (evt ? (at_last ? '0 : state_q + W'(1)) : (at_last ? IDLE : state_q));
    cnt_d   = (wrap_d && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q     <= 1'b0;
      state_q <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      x_q <= x;
      if (clr) begin
        state_q <= '0;
        wrap_q  <= 1'b0;
        cnt_q   <= '0;
      end else if (en) begin
        state_q <= state_d;
        wrap_q  <= wrap_d;
        cnt_q   <= cnt_d;
      end else begin
        wrap_q  <= 1'b0;
      end
    end
  end
  assign state    = state_q;
  assign y        = mask_ext[state_q];
  assign wrap     = wrap_q;
  assign wrap_cnt = cnt_q;
endmodule
